icache_fetch_resp: RTL and testbench

ICACHE_FETCH_RESP -- requirements
Module: icache_fetch_resp

---
 rtl/icache_pkg.sv | 36 +++
 rtl/ic_data_ram.sv | 28 ++
 rtl/icache_fetch_resp.sv | 176 +++++++++++++++++
 tb/tb_icache_fetch_resp.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and geometry for the direct-mapped instruction cache
// fetch/response block: default widths, derived field widths and FSM states.
package icache_pkg;

  localparam int unsigned IC_ADDR_W     = 32;
  localparam int unsigned IC_INST_W     = 32;
  localparam int unsigned IC_SETS       = 64;
  localparam int unsigned IC_LINE_WORDS = 4;

  // Field widths of a fetch address: [1:0] byte, then word, index, tag.
  function automatic int unsigned ic_off_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned ic_idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned ic_tag_w(input int unsigned addr_w,
                                           input int unsigned sets,
                                           input int unsigned line_words);
    return addr_w - 2 - $clog2(line_words) - $clog2(sets);
  endfunction

  localparam int unsigned IC_OFF_W = ic_off_w(IC_LINE_WORDS);
  localparam int unsigned IC_IDX_W = ic_idx_w(IC_SETS);
  localparam int unsigned IC_TAG_W = ic_tag_w(IC_ADDR_W, IC_SETS, IC_LINE_WORDS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_DATA = 2'd2,
    RESP      = 2'd3
  } ic_state_e;

endpackage

// File: rtl/ic_data_ram.sv
// Single-port instruction data store. Whole-word writes; a read issued on
// any non-write cycle appears on o_rdata after the next rising edge.
module ic_data_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Write a word, or register the addressed word for the lookup stage.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/icache_fetch_resp.sv
// Direct-mapped instruction cache front end: one-cycle lookup on hit,
// single outstanding line refill on miss, with flush and invalidate.
module icache_fetch_resp
  import icache_pkg::*;
#(
  parameter int unsigned ADDR       = IC_ADDR_W,
  parameter int unsigned INST       = IC_INST_W,
  parameter int unsigned SETS       = IC_SETS,
  parameter int unsigned LINE_WORDS = IC_LINE_WORDS
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            fetch_req,
  input  logic [ADDR-1:0] fetch_pc,
  input  logic            fetch_flush,
  input  logic            ic_inv,
  output logic            ic_ready,
  output logic            ic_valid,
  output logic [INST-1:0] ic_inst,
  output logic            mem_req,
  output logic [ADDR-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [INST-1:0] mem_rdata
);

  localparam int unsigned OFF_W  = ic_off_w(LINE_WORDS);
  localparam int unsigned IDX_W  = ic_idx_w(SETS);
  localparam int unsigned TAG_W  = ic_tag_w(ADDR, SETS, LINE_WORDS);
  localparam int unsigned RAM_AW = IDX_W + OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);
  localparam logic [ADDR-1:0]  LINE_MASK = {{(ADDR-2-OFF_W){1'b1}}, {(2+OFF_W){1'b0}}};

  ic_state_e         r_state;
  logic              r_lk_vld;
  logic [ADDR-1:0]   r_lk_pc;
  logic [SETS-1:0]   r_vld;
  logic [TAG_W-1:0]  r_tag [SETS];
  logic [OFF_W-1:0]  r_beat;
  logic              r_pend_inv;
  logic              r_flushed;
  logic              r_mem_req;
  logic [ADDR-1:0]   r_mem_addr;
  logic [INST-1:0]   r_resp_inst;

  logic [OFF_W-1:0]  w_lk_word;
  logic [IDX_W-1:0]  w_lk_idx;
  logic [TAG_W-1:0]  w_lk_tag;
  logic              w_tag_hit;
  logic              w_lk_live;
  logic              w_hit;
  logic              w_miss;
  logic              w_accept;
  logic              w_resp;
  logic              w_ram_we;
  logic [RAM_AW-1:0] w_ram_addr;
  logic [INST-1:0]   w_ram_rdata;

  // The lookup-stage PC also serves as the miss PC while refilling, since
  // nothing new is accepted until the FSM is back in IDLE.
  assign w_lk_word = r_lk_pc[2 +: OFF_W];
  assign w_lk_idx  = r_lk_pc[2+OFF_W +: IDX_W];
  assign w_lk_tag  = r_lk_pc[ADDR-1 -: TAG_W];
  assign w_tag_hit = r_vld[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

  // A flush in the lookup cycle discards that request before it can hit or miss.
  assign w_lk_live = (r_state == IDLE) && r_lk_vld && !fetch_flush;
  assign w_hit     = w_lk_live && w_tag_hit;
  assign w_miss    = w_lk_live && !w_tag_hit;

  assign ic_ready  = (r_state == IDLE) && !ic_inv && !w_miss;
  assign w_accept  = fetch_req && ic_ready;
  assign w_resp    = (r_state == RESP) && !r_flushed && !fetch_flush;

  assign ic_valid  = w_hit || w_resp;
  assign ic_inst   = w_hit ? w_ram_rdata : (w_resp ? r_resp_inst : '0);
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;

  // Refill beats own the RAM port; otherwise it reads the word at the presented PC.
  assign w_ram_we   = (r_state == MISS_DATA) && mem_rvalid && !reset_;
  assign w_ram_addr = w_ram_we ? {w_lk_idx, r_beat} : fetch_pc[2 +: RAM_AW];

  ic_data_ram #(
    .DATA_W (INST),
    .DEPTH  (SETS * LINE_WORDS)
  ) u_data_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (mem_rdata),
    .o_rdata (w_ram_rdata)
  );

  // Main control FSM: lookup stage, refill sequencing, valid bits and pending invalidate.
  always_ff @(posedge clk) begin
    if (reset_) begin
      r_state    <= IDLE;
      r_lk_vld   <= 1'b0;
      r_vld      <= '0;
      r_beat     <= '0;
      r_pend_inv <= 1'b0;
      r_flushed  <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_lk_vld <= w_accept;
          if (ic_inv) begin
            r_vld <= '0;
          end
          if (w_miss) begin
            r_state    <= MISS_REQ;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_lk_pc & LINE_MASK;
            r_beat     <= '0;
            r_flushed  <= 1'b0;
            r_pend_inv <= 1'b0;
          end
        end
        MISS_REQ: begin
          if (mem_gnt) begin
            r_mem_req <= 1'b0;
            r_state   <= MISS_DATA;
          end
        end
        MISS_DATA: begin
          if (mem_rvalid) begin
            r_beat <= r_beat + 1'b1;
            if (r_beat == LAST_BEAT) begin
              r_vld[w_lk_idx] <= 1'b1;
              r_state         <= RESP;
            end
          end
        end
        RESP: begin
          r_state    <= IDLE;
          r_pend_inv <= 1'b0;
          if (r_pend_inv || ic_inv) begin
            r_vld <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
      if ((r_state == MISS_REQ) || (r_state == MISS_DATA)) begin
        if (ic_inv) begin
          r_pend_inv <= 1'b1;
        end
        if (fetch_flush) begin
          r_flushed <= 1'b1;
        end
      end
    end
  end

  // Capture the accepted PC for the lookup stage.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lk_pc <= fetch_pc;
    end
  end

  // Refill datapath: keep the requested word for RESP and write the tag on the last beat.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      if (r_beat == w_lk_word) begin
        r_resp_inst <= mem_rdata;
      end
      if (r_beat == LAST_BEAT) begin
        r_tag[w_lk_idx] <= w_lk_tag;
      end
    end
  end

endmodule

// File: tb/tb_icache_fetch_resp.sv
// Directed and randomized bench for icache_fetch_resp against a line-level
// model of a 64-set, 4-word direct-mapped cache.
module tb_icache_fetch_resp;

  logic        clk = 1'b0;
  logic        reset_;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        fetch_flush;
  logic        ic_inv;
  logic        ic_ready;
  logic        ic_valid;
  logic [31:0] ic_inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_mis = 0;

  // Model: which line each set holds and that line's words.
  bit          m_vld  [64];
  int unsigned m_tag  [64];
  logic [31:0] m_data [64][4];
  logic [31:0] beat   [4];

  always #5 clk = ~clk;

  icache_fetch_resp dut (
    .clk        (clk),
    .reset_     (reset_),
    .fetch_req  (fetch_req),
    .fetch_pc   (fetch_pc),
    .fetch_flush(fetch_flush),
    .ic_inv     (ic_inv),
    .ic_ready   (ic_ready),
    .ic_valid   (ic_valid),
    .ic_inst    (ic_inst),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13572468;
  endfunction

  function automatic int unsigned set_of(input logic [31:0] pc);
    return (pc / 16) % 64;
  endfunction

  function automatic int unsigned word_of(input logic [31:0] pc);
    return (pc / 4) % 4;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_vld[set_of(pc)] && (m_tag[set_of(pc)] == pc / 1024);
  endfunction

  task automatic m_clear();
    for (int s = 0; s < 64; s++) m_vld[s] = 1'b0;
  endtask

  task automatic m_install(input logic [31:0] pc);
    m_vld[set_of(pc)] = 1'b1;
    m_tag[set_of(pc)] = pc / 1024;
    for (int w = 0; w < 4; w++) m_data[set_of(pc)][w] = beat[w];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Present a request for one cycle; it must be accepted.
  task automatic issue(input logic [31:0] pc);
    fetch_req = 1'b1;
    fetch_pc  = pc;
    neg();
    chk("accept_ready", ic_ready, 32'd1);
    nxt();
    fetch_req = 1'b0;
  endtask

  // Lookup cycle: the model decides hit or miss.
  task automatic lookup(input logic [31:0] pc, input string nm, output bit hit);
    hit = m_hit(pc);
    neg();
    chk({nm, "_valid"}, ic_valid, {31'd0, hit});
    if (hit) chk({nm, "_inst"}, ic_inst, m_data[set_of(pc)][word_of(pc)]);
    else     chk({nm, "_ready"}, ic_ready, 32'd0);
    nxt();
  endtask

  // Serve a refill of pc's line from beat[]; optional flush/inv on a given beat.
  task automatic refill(input logic [31:0] pc, input int gdly, input int flush_b, input int inv_b);
    logic [31:0] line;
    line = pc & ~32'hF;
    for (int i = 0; i <= gdly; i++) begin
      mem_gnt = (i == gdly);
      neg();
      chk("mreq_held", mem_req, 32'd1);
      chk("maddr_held", mem_addr, line);
      chk("mreq_ready", ic_ready, 32'd0);
      nxt();
    end
    mem_gnt = 1'b0;
    neg();
    chk("mreq_drop", mem_req, 32'd0);
    nxt();
    for (int b = 0; b < 4; b++) begin
      repeat ($urandom_range(0, 1)) nxt();
      mem_rvalid  = 1'b1;
      mem_rdata   = beat[b];
      fetch_flush = (b == flush_b);
      ic_inv      = (b == inv_b);
      neg();
      chk("beat_novalid", ic_valid, 32'd0);
      nxt();
      mem_rvalid  = 1'b0;
      fetch_flush = 1'b0;
      ic_inv      = 1'b0;
    end
    m_install(pc);
  endtask

  task automatic resp(input bit exp_v, input logic [31:0] exp_d, input string nm);
    neg();
    chk({nm, "_valid"}, ic_valid, {31'd0, exp_v});
    if (exp_v) chk({nm, "_inst"}, ic_inst, exp_d);
    chk({nm, "_ready"}, ic_ready, 32'd0);
    nxt();
  endtask

  task automatic full_miss(input logic [31:0] pc, input int gdly, input int flush_b,
                           input int inv_b, input string nm);
    bit h;
    issue(pc);
    lookup(pc, nm, h);
    chk({nm, "_is_miss"}, {31'd0, h}, 32'd0);
    refill(pc, gdly, flush_b, inv_b);
    resp(flush_b < 0, beat[word_of(pc)], {nm, "_resp"});
    if (inv_b >= 0) m_clear();
  endtask

  task automatic mem_beats(input logic [31:0] pc);
    for (int w = 0; w < 4; w++) beat[w] = memfn((pc & ~32'hF) + 32'(4 * w));
  endtask

  initial begin
    bit          h;
    logic [31:0] pc;

    reset_ = 1'b1; fetch_req = 1'b0; fetch_pc = '0; fetch_flush = 1'b0;
    ic_inv = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    m_clear();
    nxt(); nxt();
    reset_ = 1'b0;
    neg();
    chk("rst_valid", ic_valid, 32'd0);
    chk("rst_inst", ic_inst, 32'd0);
    chk("rst_mreq", mem_req, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_ready", ic_ready, 32'd1);
    nxt();

    // Cold miss on 0x100 filled with A0..A3.
    for (int w = 0; w < 4; w++) beat[w] = 32'hA0 + 32'(w);
    full_miss(32'h100, 0, -1, -1, "cold");

    // Back-to-back hits on the rest of the line.
    for (int k = 0; k <= 3; k++) begin
      fetch_req = (k < 3);
      fetch_pc  = 32'h104 + 32'(4 * k);
      neg();
      if (k > 0) begin
        chk("b2b_valid", ic_valid, 32'd1);
        chk("b2b_inst", ic_inst, 32'hA0 + 32'(k));
      end
      if (k < 3) chk("b2b_ready", ic_ready, 32'd1);
      chk("b2b_mreq", mem_req, 32'd0);
      nxt();
    end
    fetch_req = 1'b0;

    // Flush with a new request: old lookup dropped, new one served.
    issue(32'h104);
    fetch_req = 1'b1; fetch_pc = 32'h108; fetch_flush = 1'b1;
    neg();
    chk("flushreq_valid", ic_valid, 32'd0);
    chk("flushreq_ready", ic_ready, 32'd1);
    nxt();
    fetch_req = 1'b0; fetch_flush = 1'b0;
    neg();
    chk("flushreq_new_valid", ic_valid, 32'd1);
    chk("flushreq_new_inst", ic_inst, 32'hA2);
    nxt();

    // Conflicting tag evicts, with a 5-cycle grant delay; then 0x100 misses again.
    mem_beats(32'h1100);
    full_miss(32'h1100, 5, -1, -1, "evict");
    for (int w = 0; w < 4; w++) beat[w] = 32'hA0 + 32'(w);
    full_miss(32'h100, 1, -1, -1, "reload");

    // Flush on beat 2: no response, but the line is installed.
    mem_beats(32'h200);
    full_miss(32'h200, 0, 2, -1, "flushmiss");
    issue(32'h200);
    lookup(32'h200, "refetch", h);
    chk("refetch_is_hit", {31'd0, h}, 32'd1);

    // Invalidate in IDLE.
    ic_inv = 1'b1;
    neg();
    chk("inv_ready", ic_ready, 32'd0);
    nxt();
    ic_inv = 1'b0;
    m_clear();
    issue(32'h104);
    lookup(32'h104, "postinv", h);
    mem_beats(32'h104);
    refill(32'h104, 0, -1, -1);
    resp(1'b1, beat[1], "postinv_resp");

    // Invalidate during refill: refilled line is gone afterwards.
    mem_beats(32'h300);
    full_miss(32'h300, 0, -1, 1, "invmiss");
    mem_beats(32'h300);
    full_miss(32'h300, 0, -1, -1, "invmiss_again");

    // Reset mid-refill, stray beats after it.
    issue(32'h400);
    lookup(32'h400, "rstmiss", h);
    mem_gnt = 1'b1; nxt(); mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h55; nxt(); nxt();
    reset_ = 1'b1; nxt(); reset_ = 1'b0;
    m_clear();
    for (int b = 0; b < 2; b++) begin
      neg();
      chk("stray_valid", ic_valid, 32'd0);
      chk("stray_mreq", mem_req, 32'd0);
      chk("stray_ready", ic_ready, 32'd1);
      nxt();
    end
    mem_rvalid = 1'b0;
    mem_beats(32'h100);
    full_miss(32'h100, 0, -1, -1, "postrst");

    // Randomized traffic over a few conflicting lines.
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        ic_inv = 1'b1;
        neg();
        chk("rnd_inv_ready", ic_ready, 32'd0);
        nxt();
        ic_inv = 1'b0;
        m_clear();
      end
      pc = 32'($urandom_range(0, 3) * 1024 + $urandom_range(0, 3) * 16 + $urandom_range(0, 3) * 4);
      issue(pc);
      lookup(pc, "rnd", h);
      if (!h) begin
        mem_beats(pc);
        refill(pc, $urandom_range(0, 3), -1, -1);
        resp(1'b1, beat[word_of(pc)], "rnd_resp");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
